// File: rtl/bufuart_tx.sv
// Buffered 8N1 UART transmitter on the PicoRV32 native memory bus.
// Bytes written to DATA are queued in a FIFO and serialised LSB first.
module bufuart_tx #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        ser_tx,
  output logic        irq_empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [31:0]   div_q, div_d, cnt_q, cnt_d, ediv;
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          ser_tx_q, ser_tx_d, irq_q, irq_d, ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          full, empty, stall, accept, push, pop;
  logic [8:0]    level9;
  logic [31:0]   status, rd_val;

  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign empty  = (level_q == '0);
  assign level9 = 9'(level_q);
  assign ediv   = (div_q < 32'd2) ? 32'd2 : div_q;
  assign stall  = sel && (addr == 2'd1) && wstrb[0] && full;
  // The !ready term keeps a sel still held in the ready cycle from being taken twice.
  assign accept = sel && !ready_q && !stall;
  assign push   = accept && (addr == 2'd1) && wstrb[0];
  assign status = {15'd0, level9, 5'd0, empty, full, state_q != StIdle};

  always_comb begin
    rd_val = '0;
    unique case (addr)
      2'd0:    rd_val = div_q;
      2'd2:    rd_val = status;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    ser_tx_d  = ser_tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          state_d  = StStart;
          cnt_d    = ediv;
          ser_tx_d = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == 32'd1) begin
          state_d   = StData;
          cnt_d     = ediv;
          ser_tx_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StData: begin
        if (cnt_q == 32'd1) begin
          // Reload at the boundary so a DIV write only affects the following bit.
          cnt_d = ediv;
          if (bit_idx_q == 3'd7) begin
            state_d  = StStop;
            ser_tx_d = 1'b1;
          end else begin
            ser_tx_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StStop: begin
        if (cnt_q == 32'd1) begin
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            state_d  = StStart;
            cnt_d    = ediv;
            ser_tx_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    div_d    = div_q;
    for (int i = 0; i < 4; i++) begin
      if (accept && (addr == 2'd0) && wstrb[i]) div_d[8*i +: 8] = wdata[8*i +: 8];
    end
    ready_d = accept;
    rdata_d = accept ? rd_val : '0;
    irq_d   = (level_d == '0) && (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      div_q     <= 32'(DEFAULT_DIV);
      cnt_q     <= '0;
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      ser_tx_q  <= 1'b1;
      irq_q     <= 1'b1;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      ser_tx_q  <= ser_tx_d;
      irq_q     <= irq_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign ser_tx    = ser_tx_q;
  assign irq_empty = irq_q;

endmodule

// File: tb/tb_bufuart_tx.sv
// Directed bench for bufuart_tx: bus access, framing, FIFO stall, DIV handling, reset.
// ser_tx is logged every falling edge into hist (bit 0 = newest) for frame checks.
module tb_bufuart_tx;

  logic        clk = 1'b0;
  logic        reset, sel;
  logic [1:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata, rdata;
  logic        ready, ser_tx, irq_empty;

  int unsigned  n_pass  = 0;
  int unsigned  n_total = 0;
  logic [127:0] hist    = '1;

  always #5 clk = ~clk;

  bufuart_tx #(
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(104)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .addr     (addr),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .ser_tx   (ser_tx),
    .irq_empty(irq_empty)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    hist = {hist[126:0], ser_tx};
  endtask

  task automatic xfer(input logic [1:0] a, input logic [3:0] ws, input logic [31:0] wd,
                      output logic [31:0] rv);
    int n;
    tick();
    sel = 1'b1; addr = a; wstrb = ws; wdata = wd;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 300);
    chk("xfer_ready", 128'(ready), 128'(1'b1));
    rv = rdata;
    sel = 1'b0; wstrb = 4'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] ws, input logic [31:0] wd);
    logic [31:0] unused_rv;
    xfer(a, ws, wd, unused_rv);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    xfer(a, 4'b0, 32'h0, v);
    chk(tag, 128'(v), 128'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!irq_empty && n < 3000);
    chk(tag, 128'(irq_empty), 128'(1'b1));
  endtask

  initial begin
    int   n, fall;
    logic prev;
    reset = 1'b1; sel = 1'b0; addr = 2'd0; wstrb = 4'b0; wdata = 32'h0;

    // Reset state and basic register reads
    repeat (3) tick();
    chk("rst_ready", 128'(ready), 128'(1'b0));
    chk("rst_rdata", 128'(rdata), 128'(32'h0));
    chk("rst_ser_tx", 128'(ser_tx), 128'(1'b1));
    chk("rst_irq", 128'(irq_empty), 128'(1'b1));
    reset = 1'b0;
    rd_chk("t1_status", 2'd2, 32'h0000_0004);
    rd_chk("t1_div", 2'd0, 32'd104);
    tick();
    chk("t1_rdata_idle", 128'(rdata), 128'(32'h0));
    chk("t1_ready_pulse", 128'(ready), 128'(1'b0));
    rd_chk("t1_data_rd", 2'd1, 32'h0);
    rd_chk("t1_unmapped_rd", 2'd3, 32'h0);
    chk("t1_ser_idle", 128'(&hist[15:0]), 128'(1'b1));

    // Single 0x55 frame at DIV=4
    wr(2'd0, 4'hF, 32'd4);
    wr(2'd1, 4'h1, 32'h55);
    tick();
    chk("t2_start_lat", 128'(ser_tx), 128'(1'b0));
    chk("t2_irq_busy", 128'(irq_empty), 128'(1'b0));
    rd_chk("t2_status_busy", 2'd2, 32'h0000_0005);
    wait_idle("t2_idle");
    chk("t2_frame", 128'(hist[41:0]), 128'({1'b1, 40'h0F0F0F0F0F, 1'b1}));

    // Fill FIFO, then a stalled 18th write released by the next pop
    for (int k = 0; k < 17; k++) wr(2'd1, 4'h1, (k == 0) ? 32'hFF : 32'(k));
    rd_chk("t3_status_full", 2'd2, 32'h0000_1003);
    tick();
    sel = 1'b1; addr = 2'd1; wstrb = 4'h1; wdata = 32'h99;
    prev = ser_tx; fall = -1; n = 0;
    do begin
      tick();
      n++;
      if (fall < 0 && prev && !ser_tx) fall = n;
      prev = ser_tx;
    end while (!ready && n < 300);
    sel = 1'b0; wstrb = 4'b0;
    chk("t3_stall_release", 128'(n), 128'(fall + 1));
    rd_chk("t3_status_refill", 2'd2, 32'h0000_1003);
    wait_idle("t3_drain");

    // Two back-to-back frames with no gap
    wr(2'd1, 4'h1, 32'hA5);
    wr(2'd1, 4'h1, 32'h3C);
    wait_idle("t4_idle");
    chk("t4_frames", 128'(hist[81:0]), 128'({1'b1, 80'h0F0F00F0FF000FFFF00F, 1'b1}));

    // DIV byte merge, unmapped write, small divisors, mid-frame change
    wr(2'd0, 4'hF, 32'd104);
    wr(2'd0, 4'b0001, 32'h1234_56FF);
    rd_chk("t5_div_lane0", 2'd0, 32'h0000_00FF);
    wr(2'd0, 4'b0100, 32'h12AB_3456);
    rd_chk("t5_div_lane2", 2'd0, 32'h00AB_00FF);
    wr(2'd3, 4'hF, 32'hDEAD_BEEF);
    rd_chk("t5_unmapped_wr", 2'd0, 32'h00AB_00FF);
    wr(2'd0, 4'hF, 32'd0);
    wr(2'd1, 4'h1, 32'h0F);
    wait_idle("t5_idle_div0");
    chk("t5_frame_div0", 128'(hist[21:0]), 128'({1'b1, 20'h3FC03, 1'b1}));
    wr(2'd0, 4'hF, 32'd1);
    wr(2'd1, 4'h1, 32'h0F);
    wait_idle("t5_idle_div1");
    chk("t5_frame_div1", 128'(hist[21:0]), 128'({1'b1, 20'h3FC03, 1'b1}));
    wr(2'd0, 4'hF, 32'd4);
    wr(2'd1, 4'h1, 32'h55);
    repeat (16) tick();
    wr(2'd0, 4'hF, 32'd8);
    wait_idle("t5_idle_change");
    chk("t5_frame_change", 128'(hist[61:0]), 128'({1'b1, 60'h0F0F0FF00FF00FF, 1'b1}));

    // Reset mid-frame with bytes queued
    wr(2'd0, 4'hF, 32'd4);
    wr(2'd1, 4'h1, 32'h00);
    wr(2'd1, 4'h1, 32'h11);
    wr(2'd1, 4'h1, 32'h22);
    wr(2'd1, 4'h1, 32'h33);
    rd_chk("t6_status_pre", 2'd2, 32'h0000_0301);
    chk("t6_ser_data", 128'(ser_tx), 128'(1'b0));
    reset = 1'b1;
    tick();
    chk("t6_ser_reset", 128'(ser_tx), 128'(1'b1));
    chk("t6_irq_reset", 128'(irq_empty), 128'(1'b1));
    reset = 1'b0;
    rd_chk("t6_status_post", 2'd2, 32'h0000_0004);
    rd_chk("t6_div_post", 2'd0, 32'd104);
    repeat (100) tick();
    chk("t6_no_frames", 128'(&hist[99:0]), 128'(1'b1));
    chk("t6_irq_final", 128'(irq_empty), 128'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
